tv_recorder: RTL and testbench
==============================

Name: tv_recorder

Overview:
- Synthesizable test-vector capture block: the writer counterpart to the bench-side vector reader.
- Samples the arithmetic unit's stimulus and response {op, A, B, Y} into an on-chip buffer during a record window.
- Streams the captured words back out over a valid/ready interface so they can be dumped into a 21-bit .tv vector file.
- Sits beside the part1part2 datapath on the same clock and taps its ports.

Parameters:
- DEPTH, 1024, number of 21-bit vector words stored; power of two, minimum 4.
- AW, $clog2(DEPTH), address width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  pulse: clear buffer and begin recording.
- stop  input  1  pulse: end recording.
- cap_en  input  1  capture the current vector this cycle (only while recording).
- op  input  1  operation select tapped from datapath.
- a  input  8  operand A.
- b  input  4  operand B.
- y  input  8  datapath result Y.
- dump_req  input  1  pulse: stream out buffered vectors.
- out_ready  input  1  sink accepts out_data.
- out_valid  output  1  out_data holds a valid vector.
- out_data  output  21  vector word, packed {op, a[7:0], b[3:0], y[7:0]}, MSB = op.
- count  output  AW+1  number of words currently stored.
- busy  output  1  high in REC or DUMP.
- done  output  1  one-cycle pulse when a dump completes.
- overflow  output  1  sticky: a capture was dropped because the buffer was full.

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of clk. Forces state IDLE, wr_ptr = rd_ptr = 0, count = 0, out_valid = 0, out_data = 0, done = 0, overflow = 0, busy = 0. Buffer contents are not cleared and are not relied on. Reset wins over every other input in the same cycle, including mid-record and mid-dump.
- FSM states: IDLE, REC, DUMP.
- IDLE:
  - start → REC; wr_ptr = 0, count = 0, overflow = 0.
  - dump_req with count > 0 → DUMP; rd_ptr = 0.
  - dump_req with count = 0 → stay IDLE; done pulses the next cycle and out_valid is never raised.
  - start and dump_req in the same cycle: start wins.
  - cap_en is ignored.
- REC:
  - On each cycle with cap_en = 1 and count < DEPTH: write the packed word at wr_ptr, then wr_ptr++ and count++. Both updates are visible the next cycle.
  - cap_en = 1 with count = DEPTH: word dropped, overflow set (sticky until the next start or reset), count holds at DEPTH.
  - stop → IDLE. If cap_en is also high in that cycle, that capture still occurs.
  - start while in REC restarts recording: pointers and count cleared, any cap_en in that cycle ignored.
  - dump_req is ignored.
- DUMP:
  - out_valid first rises 1 cycle after entering DUMP, with out_data = word[0].
  - A transfer occurs on a cycle with out_valid & out_ready.
  - Throughput: one word per cycle when out_ready is held high; no bubbles between words.
  - While out_valid = 1 and out_ready = 0, out_data and out_valid hold stable.
  - After the transfer of word[count-1]: out_valid drops the next cycle, done pulses that same cycle, state returns to IDLE.
  - count is unchanged by a dump, so the same buffer can be re-dumped.
  - start, stop and cap_en are ignored while in DUMP.
- Wrap-around: wr_ptr never wraps, because recording saturates at DEPTH. rd_ptr ranges from 0 to count-1.
- busy = (state != IDLE), registered with the state.

Decomposition:
- Shared package tv_pkg:
  - VEC_W = 21.
  - Packed struct tv_vec_t {logic op; logic [7:0] a; logic [3:0] b; logic [7:0] y;}.
  - State enum tv_rec_state_e {IDLE, REC, DUMP}.
- Sub-module tv_ram: simple dual-port memory, DEPTH x VEC_W, synchronous write, registered synchronous read. The DUMP prefetch logic in tv_recorder absorbs the 1-cycle read latency.

Test Plan:
- Record 10 vectors, then dump with out_ready = 1: pulse start, drive cap_en for 10 cycles with e.g. {op=1, a=8'd200, b=4'd3, y=8'd50} then other values; pulse stop; pulse dump_req. Expect count = 10, exactly 10 words in capture order on consecutive cycles, done pulses once, busy then low.
- Backpressure: dump 5 words while toggling out_ready 1,0,0,1,... → each word is transferred exactly once, out_data stays stable during every stall, done only after the 5th transfer.
- Overflow (DEPTH = 4): 6 cap_en cycles in REC → count = 4, overflow = 1, the dump returns only the first 4 words; a following start clears overflow and count.
- Empty dump: reset, then dump_req → out_valid stays 0, done pulses the next cycle, state stays IDLE.
- Reset mid-dump: drop rst_n for one cycle after the 3rd transfer of 8 → next cycle out_valid = 0, count = 0, busy = 0, done = 0.
- Simultaneous events:
  - start and dump_req in the same IDLE cycle → enters REC.
  - stop and cap_en in the same REC cycle → that vector is stored (count increments).

Source files
------------

// File: rtl/tv_pkg.sv
// tv_pkg: shared types for the test-vector recorder
package tv_pkg;
  localparam int VEC_W = 21;
  typedef struct packed {
    logic       op;
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] y;
  } tv_vec_t;
  typedef enum logic [1:0] {IDLE, REC, DUMP} tv_rec_state_e;
endpackage

// File: rtl/tv_ram.sv
// tv_ram: simple dual-port vector buffer, synchronous write, registered read
module tv_ram
  import tv_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [VEC_W-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [VEC_W-1:0] rdata
);
  logic [VEC_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/tv_recorder.sv
// tv_recorder: captures {op,a,b,y} vectors during a record window and streams them out
module tv_recorder
  import tv_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cap_en,
  input  logic             op,
  input  logic [7:0]       a,
  input  logic [3:0]       b,
  input  logic [7:0]       y,
  input  logic             dump_req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [VEC_W-1:0] out_data,
  output logic [AW:0]      count,
  output logic             busy,
  output logic             done,
  output logic             overflow
);
  localparam logic [AW:0] full_cnt = (AW+1)'(DEPTH);
  tv_rec_state_e state, state_n;
  tv_vec_t vec;
  logic [AW-1:0] rd_ptr, raddr;
  logic [VEC_W-1:0] ram_q;
  logic full, xfer, last, we, re;
  assign vec = '{op: op, a: a, b: b, y: y};
  always_comb begin
    full  = count == full_cnt;
    xfer  = out_valid && out_ready;
    last  = rd_ptr == AW'(count - 1'b1);
    we    = state == REC && !start && cap_en && !full;
    // read one word ahead while the current word is being handed off, so no bubbles
    re    = state == DUMP && (!out_valid || out_ready);
    raddr = out_valid ? rd_ptr + 1'b1 : rd_ptr;
    state_n = state == IDLE ? (start ? REC : (dump_req && count != '0) ? DUMP : IDLE)
            : state == REC  ? ((stop && !start) ? IDLE : REC)
            : ((xfer && last) ? IDLE : DUMP);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      done      <= (state == IDLE && dump_req && !start && count == '0) || (state == DUMP && xfer && last);
      out_valid <= state == DUMP && !(xfer && last);
      rd_ptr    <= state == DUMP ? (xfer ? rd_ptr + 1'b1 : rd_ptr) : '0;
      if (state != DUMP && start) begin
        count    <= '0;
        overflow <= 1'b0;
      end else if (we) count <= count + 1'b1;
      else if (state == REC && cap_en && full) overflow <= 1'b1;
    end
  end
  assign busy     = state != IDLE;
  assign out_data = out_valid ? ram_q : '0;
  tv_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (count[AW-1:0]),
    .wdata (vec),
    .re    (re),
    .raddr (raddr),
    .rdata (ram_q)
  );
endmodule

// File: tb/tb_tv_recorder.sv
// tb_tv_recorder: directed self-checking bench for tv_recorder (DEPTH = 16)
module tb_tv_recorder;
  logic clk = 0, rst_n = 0, start = 0, stop = 0, cap_en = 0, op = 0;
  logic [7:0] a = 0, y = 0;
  logic [3:0] b = 0;
  logic dump_req = 0, out_ready = 0;
  logic out_valid, busy, done, overflow;
  logic [20:0] out_data;
  logic [4:0] count;
  logic [20:0] exp_w [16];
  int checks = 0, failures = 0;

  tv_recorder #(.DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cap_en(cap_en),
    .op(op), .a(a), .b(b), .y(y), .dump_req(dump_req), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .count(count), .busy(busy),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // n capture cycles, the last one coinciding with stop
  task automatic record(input int n, input int seed);
    start = 1; tick; start = 0;
    chk("rec_busy", busy, 1);
    chk("rec_count0", count, 0);
    for (int i = 0; i < n; i++) begin
      if (i == 0 && seed == 0) begin
        op = 1; a = 8'd200; b = 4'd3; y = 8'd50;
      end else begin
        op = i[0]; a = 8'(i * 17 + seed); b = 4'(i + seed); y = 8'(i * 29 + seed * 3);
      end
      if (i < 16) exp_w[i] = {op, a, b, y};
      cap_en = 1; stop = (i == n - 1);
      tick;
    end
    cap_en = 0; stop = 0;
    chk("rec_count", count, (n > 16) ? 16 : n);
    chk("rec_overflow", overflow, n > 16);
    chk("rec_idle", busy, 0);
  endtask

  // bp: out_ready follows 1,0,0,1,0,0,...
  task automatic do_dump(input int n, input bit bp);
    int k = 0, cyc = 0;
    bit stalled = 0;
    logic [20:0] held = '0;
    dump_req = 1; tick; dump_req = 0;
    chk("dump_busy", busy, 1);
    chk("dump_first_valid", out_valid, 0);
    while (k < n && cyc < 200) begin
      out_ready = bp ? (cyc % 3 == 0) : 1'b1;
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, held);
      end
      chk("dump_no_done", done, 0);
      if (out_valid && out_ready) begin
        chk("dump_word", out_data, exp_w[k]);
        k++;
        stalled = 0;
      end else begin
        stalled = out_valid;
        held = out_data;
      end
      tick; cyc++;
    end
    out_ready = 0;
    chk("dump_words", k, n);
    if (!bp) chk("dump_cycles", cyc, n + 1);
    chk("dump_done", done, 1);
    chk("dump_valid_low", out_valid, 0);
    chk("dump_idle", busy, 0);
    chk("dump_count_kept", count, n);
    tick;
    chk("dump_done_pulse", done, 0);
    chk("dump_valid_stays", out_valid, 0);
  endtask

  initial begin
    int k;
    tick; tick;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1; tick;

    // empty dump
    dump_req = 1; tick; dump_req = 0;
    chk("empty_done", done, 1);
    chk("empty_valid", out_valid, 0);
    chk("empty_busy", busy, 0);
    tick;
    chk("empty_done_pulse", done, 0);
    chk("empty_valid2", out_valid, 0);

    // start beats dump_req; cap_en while idle is ignored
    cap_en = 1; tick;
    chk("idle_cap_ignored", count, 0);
    cap_en = 0;
    start = 1; dump_req = 1; tick; start = 0; dump_req = 0;
    chk("start_wins_busy", busy, 1);
    chk("start_wins_valid", out_valid, 0);
    stop = 1; tick; stop = 0;
    chk("stop_idle", busy, 0);

    record(10, 0);
    chk("first_word_pack", exp_w[0], 21'h1C8332);
    do_dump(10, 0);
    do_dump(10, 0);

    record(5, 7);
    do_dump(5, 1);

    // start inside REC discards the window, including that cycle's capture
    start = 1; tick; start = 0;
    cap_en = 1; tick; tick; tick;
    chk("restart_pre", count, 3);
    start = 1; tick; start = 0;
    chk("restart_count", count, 0);
    tick;
    chk("restart_recount", count, 1);
    cap_en = 0; stop = 1; tick; stop = 0;

    // dump ignores start/stop/cap_en
    record(4, 3);
    dump_req = 1; tick; dump_req = 0;
    start = 1; cap_en = 1; stop = 1; out_ready = 0; tick; tick;
    start = 0; cap_en = 0; stop = 0;
    chk("dump_ign_busy", busy, 1);
    chk("dump_ign_count", count, 4);
    chk("dump_ign_word0", out_data, exp_w[0]);
    out_ready = 1;
    for (int i = 1; i < 4; i++) begin tick; chk("dump_ign_word", out_data, exp_w[i]); end
    tick; out_ready = 0;
    chk("dump_ign_done", done, 1);

    record(18, 11);
    do_dump(16, 0);
    start = 1; tick; start = 0;
    chk("ovf_clear", overflow, 0);
    chk("ovf_count_clear", count, 0);
    stop = 1; tick; stop = 0;

    // reset after the 3rd of 8 transfers
    record(8, 5);
    dump_req = 1; tick; dump_req = 0;
    out_ready = 1; k = 0;
    for (int c = 0; c < 50 && k < 3; c++) begin
      if (out_valid) begin
        chk("mid_word", out_data, exp_w[k]);
        k++;
      end
      tick;
    end
    chk("mid_xfers", k, 3);
    chk("mid_still_busy", busy, 1);
    rst_n = 0; tick; rst_n = 1; out_ready = 0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    tick;
    chk("mid_rst_done2", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
